ip_header_rx: RTL

Receive-side IPv4 header parser, mirroring the transmit header generator. It sits after the Ethernet header receiver and consumes the 20-byte IPv4 header from the byte stream. It validates the header fields and the header checksum, and extracts the source address, destination address and UDP length for the UDP receive stage. Each header ends in exactly one pulse: `ip_header_rx_done` on success or `ip_header_rx_err` on failure.

---
 rtl/ip_header_rx_if.sv | 22 ++
 rtl/ip_header_rx.sv | 139 +++++++++++++
 2 files changed

// File: rtl/ip_header_rx_if.sv
// Byte stream feeding the IPv4 header parser.
// Handshake: there is no back-pressure. eth_header_ip_rx_done is a one-cycle
// start pulse; after it, a byte on data_in is consumed on every rising edge
// where data_valid is high. Cycles with data_valid low carry nothing and
// stall the parser.
interface ip_header_rx_if;
  logic       eth_header_ip_rx_done;
  logic [7:0] data_in;
  logic       data_valid;

  modport master (
    output eth_header_ip_rx_done,
    output data_in,
    output data_valid
  );

  modport slave (
    input eth_header_ip_rx_done,
    input data_in,
    input data_valid
  );
endinterface

// File: rtl/ip_header_rx.sv
// IPv4 receive header parser: consumes the 20-byte header, validates the
// fixed fields, the checksum and optionally the destination address, and
// publishes source/destination address and UDP length on success.
module ip_header_rx #(
  parameter logic [31:0] LOCAL_IP_ADDR = 32'hC0A8_0001,
  parameter int          ADDR_FILTER   = 1
) (
  input  logic          aclk,
  input  logic          aresetn,
  ip_header_rx_if.slave hdr_if,
  output logic [31:0]   ip_s_addr,
  output logic [31:0]   ip_d_addr,
  output logic [15:0]   udp_len,
  output logic          ip_header_rx_done,
  output logic          ip_header_rx_err,
  output logic [2:0]    err_code,
  output logic [1:0]    state_dbg
);

  typedef enum logic [1:0] {
    WAIT_START = 2'd0,
    HEADER     = 2'd1,
    CHECK      = 2'd2
  } state_t;

  state_t      state;
  logic [4:0]  idx;
  logic [31:0] acc;
  logic [7:0]  prev_byte;
  logic [7:0]  byte0;
  logic [15:0] total_len;
  logic [15:0] frag;
  logic [7:0]  protocol;
  logic [31:0] s_sh;
  logic [31:0] d_sh;

  logic [31:0] fold1;
  logic [31:0] fold2;
  logic [2:0]  check_code;

  assign state_dbg = state;

  // Checksum fold and prioritised header checks; 0 means the header passes.
  always_comb begin
    fold1      = {16'd0, acc[15:0]} + {16'd0, acc[31:16]};
    fold2      = {16'd0, fold1[15:0]} + {16'd0, fold1[31:16]};
    check_code = 3'd0;
    if (byte0 != 8'h45)
      check_code = 3'd1;
    else if (protocol != 8'h11)
      check_code = 3'd2;
    else if ((frag & 16'h3FFF) != 16'd0)
      check_code = 3'd3;
    else if (total_len < 16'd28)
      check_code = 3'd4;
    else if (fold2 != 32'h0000_FFFF)
      check_code = 3'd5;
    else if ((ADDR_FILTER != 0) && (d_sh != LOCAL_IP_ADDR))
      check_code = 3'd6;
  end

  // Parser FSM: byte capture, checksum accumulation and result publication.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state             <= WAIT_START;
      idx               <= 5'd0;
      acc               <= 32'd0;
      prev_byte         <= 8'd0;
      byte0             <= 8'd0;
      total_len         <= 16'd0;
      frag              <= 16'd0;
      protocol          <= 8'd0;
      s_sh              <= 32'd0;
      d_sh              <= 32'd0;
      ip_s_addr         <= 32'd0;
      ip_d_addr         <= 32'd0;
      udp_len           <= 16'd0;
      ip_header_rx_done <= 1'b0;
      ip_header_rx_err  <= 1'b0;
      err_code          <= 3'd0;
    end else begin
      ip_header_rx_done <= 1'b0;
      ip_header_rx_err  <= 1'b0;
      case (state)
        WAIT_START: begin
          if (hdr_if.eth_header_ip_rx_done) begin
            state <= HEADER;
            idx   <= 5'd0;
            acc   <= 32'd0;
          end
        end
        HEADER: begin
          if (hdr_if.data_valid) begin
            prev_byte <= hdr_if.data_in;
            if (idx[0])
              acc <= acc + {16'd0, prev_byte, hdr_if.data_in};
            case (idx)
              5'd0:  byte0           <= hdr_if.data_in;
              5'd2:  total_len[15:8] <= hdr_if.data_in;
              5'd3:  total_len[7:0]  <= hdr_if.data_in;
              5'd6:  frag[15:8]      <= hdr_if.data_in;
              5'd7:  frag[7:0]       <= hdr_if.data_in;
              5'd9:  protocol        <= hdr_if.data_in;
              5'd12: s_sh[31:24]     <= hdr_if.data_in;
              5'd13: s_sh[23:16]     <= hdr_if.data_in;
              5'd14: s_sh[15:8]      <= hdr_if.data_in;
              5'd15: s_sh[7:0]       <= hdr_if.data_in;
              5'd16: d_sh[31:24]     <= hdr_if.data_in;
              5'd17: d_sh[23:16]     <= hdr_if.data_in;
              5'd18: d_sh[15:8]      <= hdr_if.data_in;
              5'd19: d_sh[7:0]       <= hdr_if.data_in;
              default: ;
            endcase
            if (idx == 5'd19) begin
              state <= CHECK;
              idx   <= 5'd0;
            end else begin
              idx <= idx + 5'd1;
            end
          end
        end
        CHECK: begin
          state <= WAIT_START;
          if (check_code == 3'd0) begin
            ip_s_addr         <= s_sh;
            ip_d_addr         <= d_sh;
            udp_len           <= total_len - 16'd20;
            ip_header_rx_done <= 1'b1;
          end else begin
            ip_header_rx_err <= 1'b1;
            err_code         <= check_code;
          end
        end
        default: state <= WAIT_START;
      endcase
    end
  end

endmodule
